// File: rtl/add_checker_pkg.sv
// -----------------------------------------------------------------------------
// add_checker_pkg
// Shared types and defaults for the adder result checker.
//   state_t        : run-control FSM states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH  : default adder operand width
//   DEFAULT_CNT_W  : default width of num_tests / test_count / err_count
//   sum_t          : {cout,out} sum for the default operand width
// -----------------------------------------------------------------------------
package add_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_CNT_W = 8;

  typedef logic [DEFAULT_WIDTH:0] sum_t;

endpackage

// File: rtl/add_ref_model.sv
// -----------------------------------------------------------------------------
// add_ref_model
// Combinational golden adder: o_sum = i_a + i_b, one bit wider than the
// operands so the carry is never lost.
// Ports:
//   i_a   in  WIDTH    operand A
//   i_b   in  WIDTH    operand B
//   o_sum out WIDTH+1  full-precision sum ({carry, sum})
// -----------------------------------------------------------------------------
module add_ref_model #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH:0]   o_sum
);

  assign o_sum = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/add_result_checker.sv
// -----------------------------------------------------------------------------
// add_result_checker
// Checks the 4-bit adder downstream: accepts (num1, num2, {cout,out}) vectors
// over valid/ready, recomputes the golden sum, pulses a per-vector verdict and
// keeps saturating pass/error counters. A run is framed by start/done.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, num_tests      begin a run of num_tests vectors (IDLE/DONE only)
//   in_valid / in_ready   vector handshake
//   num1, num2, out, cout operands and observed adder result
//   res_valid, pass       one-cycle verdict pulse and its result
//   test_count, err_count saturating verdict / failure counters for the run
//   done                  run complete, held until the next honoured start
//
// Optional feature (macro ERR_CAPTURE_EN): adds first_err_valid, first_err_a,
// first_err_b and first_err_sum, which latch the first failing vector of a run.
//
// Pipeline: S1 registers the transferred vector, S2 registers the verdict, so a
// vector transferred in cycle k produces its res_valid pulse in cycle k+2.
// -----------------------------------------------------------------------------
module add_result_checker
  import add_checker_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_tests,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [WIDTH-1:0] out,
  input  logic             cout,
  output logic             res_valid,
  output logic             pass,
  output logic [CNT_W-1:0] test_count,
  output logic [CNT_W-1:0] err_count,
  output logic             done
`ifdef ERR_CAPTURE_EN
  ,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output logic [WIDTH:0]   first_err_sum
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_num_tests;
  logic [CNT_W-1:0] r_acc_count;
  logic [CNT_W-1:0] r_test_count;
  logic [CNT_W-1:0] r_err_count;
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [WIDTH:0]   r_s1_obs;
  logic             r_res_valid;
  logic             r_pass;

  logic             w_start_ok;
  logic             w_accept_done;
  logic             w_xfer;
  logic             w_match;
  logic [WIDTH:0]   w_expected;

  // start is only honoured outside RUN; a start during a run is dropped.
  assign w_start_ok    = start && (r_state != RUN);
  assign w_accept_done = (r_acc_count >= r_num_tests);
  assign in_ready      = (r_state == RUN) && !w_accept_done;
  assign w_xfer        = in_valid && in_ready;

  add_ref_model #(
    .WIDTH (WIDTH)
  ) u_ref_model (
    .i_a   (r_s1_a),
    .i_b   (r_s1_b),
    .o_sum (w_expected)
  );

  assign w_match = (w_expected == r_s1_obs);

  // Leave RUN once every vector is accepted and S1 is empty: the verdict of
  // the last vector (if any) is in S2 this cycle, so DONE follows its pulse.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_accept_done && !r_s1_valid) w_state_next = DONE;
      DONE:    if (start) w_state_next = RUN;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_num_tests  <= '0;
      r_acc_count  <= '0;
      r_test_count <= '0;
      r_err_count  <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_a       <= '0;
      r_s1_b       <= '0;
      r_s1_obs     <= '0;
      r_res_valid  <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_s1_valid  <= w_xfer;
      r_res_valid <= r_s1_valid;
      r_pass      <= r_s1_valid && w_match;

      if (w_xfer) begin
        r_s1_a   <= num1;
        r_s1_b   <= num2;
        r_s1_obs <= {cout, out};
      end

      if (w_start_ok) begin
        r_num_tests  <= num_tests;
        r_acc_count  <= '0;
        r_test_count <= '0;
        r_err_count  <= '0;
      end else begin
        if (w_xfer) begin
          r_acc_count <= r_acc_count + 1'b1;
        end
        // Counters move on the same edge that launches the verdict pulse.
        if (r_s1_valid) begin
          if (r_test_count != CNT_MAX) begin
            r_test_count <= r_test_count + 1'b1;
          end
          if (!w_match && (r_err_count != CNT_MAX)) begin
            r_err_count <= r_err_count + 1'b1;
          end
        end
      end
    end
  end

  assign res_valid  = r_res_valid;
  assign pass       = r_pass;
  assign test_count = r_test_count;
  assign err_count  = r_err_count;
  assign done       = (r_state == DONE);

`ifdef ERR_CAPTURE_EN
  logic             r_fe_valid;
  logic [WIDTH-1:0] r_fe_a;
  logic [WIDTH-1:0] r_fe_b;
  logic [WIDTH:0]   r_fe_sum;

  // Capture the observed (faulty) result of the first failing vector only.
  always_ff @(posedge clk) begin
    if (rst || w_start_ok) begin
      r_fe_valid <= 1'b0;
      r_fe_a     <= '0;
      r_fe_b     <= '0;
      r_fe_sum   <= '0;
    end else if (r_s1_valid && !w_match && !r_fe_valid) begin
      r_fe_valid <= 1'b1;
      r_fe_a     <= r_s1_a;
      r_fe_b     <= r_s1_b;
      r_fe_sum   <= r_s1_obs;
    end
  end

  assign first_err_valid = r_fe_valid;
  assign first_err_a     = r_fe_a;
  assign first_err_b     = r_fe_b;
  assign first_err_sum   = r_fe_sum;
`endif

endmodule

// File: tb/tb_add_result_checker.sv
module tb_add_result_checker;
  import add_checker_pkg::*;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, in_valid, cout;
  logic [7:0] num_tests;
  logic [3:0] num1, num2, out;
  logic       in_ready, res_valid, pass, done;
  logic [7:0] test_count, err_count;

  logic       sat_start;
  logic [1:0] sat_num_tests;
  logic       sat_in_ready, sat_res_valid, sat_pass, sat_done;
  logic [1:0] sat_test_count, sat_err_count;

`ifdef ERR_CAPTURE_EN
  logic       fe_valid, sat_fe_valid;
  logic [3:0] fe_a, fe_b, sat_fe_a, sat_fe_b;
  logic [4:0] fe_sum, sat_fe_sum;
`endif

  add_result_checker #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .num_tests(num_tests),
    .in_valid(in_valid), .in_ready(in_ready), .num1(num1), .num2(num2),
    .out(out), .cout(cout), .res_valid(res_valid), .pass(pass),
    .test_count(test_count), .err_count(err_count), .done(done)
`ifdef ERR_CAPTURE_EN
    , .first_err_valid(fe_valid), .first_err_a(fe_a), .first_err_b(fe_b),
    .first_err_sum(fe_sum)
`endif
  );

  add_result_checker #(.WIDTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(sat_start), .num_tests(sat_num_tests),
    .in_valid(in_valid), .in_ready(sat_in_ready), .num1(num1), .num2(num2),
    .out(out), .cout(cout), .res_valid(sat_res_valid), .pass(sat_pass),
    .test_count(sat_test_count), .err_count(sat_err_count), .done(sat_done)
`ifdef ERR_CAPTURE_EN
    , .first_err_valid(sat_fe_valid), .first_err_a(sat_fe_a),
    .first_err_b(sat_fe_b), .first_err_sum(sat_fe_sum)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: every accepted vector is owed one verdict exactly two
  // cycles after the cycle it was transferred in.
  typedef struct { int due; bit ok; } exp_t;
  exp_t q[$];

  int         s_cyc;
  bit         s_in_ready, s_res_valid, s_pass, s_done, s_xfer;
  logic [7:0] s_tc, s_ec;
  bit         e_pulse, e_pass;

  function automatic sum_t golden(input logic [3:0] a, input logic [3:0] b);
    int s;
    s = int'(a) + int'(b);
    return sum_t'(s);
  endfunction

  // Drive one cycle, snapshot outputs mid-cycle and update the model.
  task automatic step(input bit v, input logic [3:0] a, input logic [3:0] b, input sum_t obs);
    exp_t e;
    in_valid = v; num1 = a; num2 = b; {cout, out} = obs;
    @(negedge clk);
    s_cyc = cyc; s_in_ready = in_ready; s_res_valid = res_valid; s_pass = pass;
    s_done = done; s_tc = test_count; s_ec = err_count;
    s_xfer = in_valid && in_ready;
    if (s_xfer) begin
      e.due = cyc + 2;
      e.ok  = (int'(a) + int'(b)) == int'(obs);
      q.push_back(e);
    end
    e_pulse = 1'b0; e_pass = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      e_pulse = 1'b1; e_pass = e.ok;
    end
    if (rst) q.delete();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [7:0] n);
    num_tests = n; start = 1'b1;
    step(1'b0, 4'd0, 4'd0, 5'd0);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) step(1'b0, 4'd0, 4'd0, 5'd0);
    n_cmp++;
    if ({s_in_ready, s_res_valid, s_pass, s_done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: ready/valid/pass/done=%b required 0000", {s_in_ready, s_res_valid, s_pass, s_done});
    end
    n_cmp++;
    if (s_tc !== 8'd0 || s_ec !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_counts: test_count=%0d err_count=%0d required 0/0", s_tc, s_ec);
    end
    rst = 1'b0;
  endtask

  task automatic test_rst_midrun;
    do_start(8'd5);
    step(1'b1, 4'd3, 4'd4, 5'd7);
    step(1'b1, 4'd9, 4'd9, 5'd18);
    rst = 1'b1;
    step(1'b0, 4'd0, 4'd0, 5'd0);
    n_cmp++;
    if (s_res_valid !== e_pulse || (e_pulse && s_pass !== e_pass)) begin
      n_fail++;
      $display("FAIL rst_mid verdict @%0d: valid=%b pass=%b required %b/%b", s_cyc, s_res_valid, s_pass, e_pulse, e_pass);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 4'd1, 4'd1, 5'd2);
      n_cmp++;
      if (s_res_valid !== 1'b0 || s_in_ready !== 1'b0 || s_done !== 1'b0 || s_pass !== 1'b0 ||
          s_tc !== 8'd0 || s_ec !== 8'd0) begin
        n_fail++;
        $display("FAIL rst_mid_after @%0d: valid=%b ready=%b done=%b pass=%b tc=%0d ec=%0d required all 0",
                 s_cyc, s_res_valid, s_in_ready, s_done, s_pass, s_tc, s_ec);
      end
    end
  endtask

  task automatic test_correct_sums;
    logic [3:0] va[5];
    logic [3:0] vb[5];
    int pulses, last_pulse, done_cyc;
    va = '{4'd0, 4'd1, 4'd15, 4'd10, 4'd15};
    vb = '{4'd0, 4'd2, 4'd1, 4'd5, 4'd15};
    pulses = 0; last_pulse = -1; done_cyc = -1;
    do_start(8'd5);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, va[i], vb[i], golden(va[i], vb[i]));
      n_cmp++;
      if (!s_xfer) begin
        n_fail++;
        $display("FAIL sums_xfer vec%0d: in_ready=%b required 1", i, s_in_ready);
      end
      n_cmp++;
      if (s_res_valid !== e_pulse || (e_pulse && s_pass !== e_pass)) begin
        n_fail++;
        $display("FAIL sums verdict @%0d: valid=%b pass=%b required %b/%b", s_cyc, s_res_valid, s_pass, e_pulse, e_pass);
      end
      if (s_res_valid) begin pulses++; last_pulse = s_cyc; end
    end
    for (int i = 0; i < 12 && done_cyc < 0; i++) begin
      step(1'b0, 4'd0, 4'd0, 5'd0);
      n_cmp++;
      if (s_res_valid !== e_pulse || (e_pulse && s_pass !== e_pass)) begin
        n_fail++;
        $display("FAIL sums verdict @%0d: valid=%b pass=%b required %b/%b", s_cyc, s_res_valid, s_pass, e_pulse, e_pass);
      end
      if (s_res_valid) begin pulses++; last_pulse = s_cyc; end
      if (s_done) done_cyc = s_cyc;
    end
    n_cmp++;
    if (pulses != 5 || done_cyc != last_pulse + 1) begin
      n_fail++;
      $display("FAIL sums_done: pulses=%0d done@%0d last_pulse@%0d required 5 and done one cycle after", pulses, done_cyc, last_pulse);
    end
    n_cmp++;
    if (s_tc !== 8'd5 || s_ec !== 8'd0) begin
      n_fail++;
      $display("FAIL sums_counts: tc=%0d ec=%0d required 5/0", s_tc, s_ec);
    end
  endtask

  task automatic test_error_vector;
    bit got_done;
    got_done = 1'b0;
    do_start(8'd3);
    step(1'b1, 4'd15, 4'd1, 5'd0);
    step(1'b1, 4'd3, 4'd3, 5'd1);
    step(1'b1, 4'd2, 4'd2, 5'd4);
    for (int i = 0; i < 12 && !got_done; i++) begin
      step(1'b0, 4'd0, 4'd0, 5'd0);
      n_cmp++;
      if (s_res_valid !== e_pulse || (e_pulse && s_pass !== e_pass)) begin
        n_fail++;
        $display("FAIL err verdict @%0d: valid=%b pass=%b required %b/%b", s_cyc, s_res_valid, s_pass, e_pulse, e_pass);
      end
      got_done = s_done;
    end
    n_cmp++;
    if (!got_done || s_tc !== 8'd3 || s_ec !== 8'd2) begin
      n_fail++;
      $display("FAIL err_counts: done=%b tc=%0d ec=%0d required 1/3/2", got_done, s_tc, s_ec);
    end
`ifdef ERR_CAPTURE_EN
    n_cmp++;
    if (fe_valid !== 1'b1 || fe_a !== 4'd15 || fe_b !== 4'd1 || fe_sum !== 5'd0) begin
      n_fail++;
      $display("FAIL first_err: valid=%b a=%0d b=%0d sum=%0d required 1/15/1/0", fe_valid, fe_a, fe_b, fe_sum);
    end
`endif
  endtask

  task automatic test_back_to_back;
    int xfers;
    bit got_done;
    logic [3:0] a, b;
    xfers = 0; got_done = 1'b0;
    do_start(8'd3);
    for (int i = 0; i < 8; i++) begin
      a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15));
      step(1'b1, a, b, golden(a, b));
      n_cmp++;
      if (s_in_ready !== (i < 3)) begin
        n_fail++;
        $display("FAIL b2b_ready cycle%0d: in_ready=%b required %b", i, s_in_ready, (i < 3));
      end
      n_cmp++;
      if (s_res_valid !== e_pulse || (e_pulse && s_pass !== e_pass)) begin
        n_fail++;
        $display("FAIL b2b verdict @%0d: valid=%b pass=%b required %b/%b", s_cyc, s_res_valid, s_pass, e_pulse, e_pass);
      end
      if (s_xfer) xfers++;
      if (s_done) got_done = 1'b1;
    end
    n_cmp++;
    if (xfers != 3 || !got_done || s_tc !== 8'd3) begin
      n_fail++;
      $display("FAIL b2b_total: xfers=%0d done=%b tc=%0d required 3/1/3", xfers, got_done, s_tc);
    end
  endtask

  task automatic test_zero_and_ignored_start;
    int xfers;
    bit got_done;
    xfers = 0; got_done = 1'b0;
    do_start(8'd0);
    step(1'b0, 4'd0, 4'd0, 5'd0);
    n_cmp++;
    if (s_done !== 1'b0 || s_res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_c1: done=%b valid=%b required 0/0", s_done, s_res_valid);
    end
    step(1'b0, 4'd0, 4'd0, 5'd0);
    n_cmp++;
    if (s_done !== 1'b1 || s_res_valid !== 1'b0 || s_tc !== 8'd0) begin
      n_fail++;
      $display("FAIL zero_c2: done=%b valid=%b tc=%0d required 1/0/0", s_done, s_res_valid, s_tc);
    end
    do_start(8'd4);
    for (int i = 0; i < 16 && !got_done; i++) begin
      if (i == 2) begin start = 1'b1; num_tests = 8'd1; end
      step(1'b1, 4'(i), 4'd7, golden(4'(i), 4'd7));
      start = 1'b0;
      n_cmp++;
      if (s_res_valid !== e_pulse || (e_pulse && s_pass !== e_pass)) begin
        n_fail++;
        $display("FAIL ign verdict @%0d: valid=%b pass=%b required %b/%b", s_cyc, s_res_valid, s_pass, e_pulse, e_pass);
      end
      if (s_xfer) xfers++;
      got_done = s_done;
    end
    n_cmp++;
    if (xfers != 4 || !got_done || s_tc !== 8'd4 || s_ec !== 8'd0) begin
      n_fail++;
      $display("FAIL ignored_start: xfers=%0d done=%b tc=%0d ec=%0d required 4/1/4/0", xfers, got_done, s_tc, s_ec);
    end
  endtask

  task automatic test_random;
    int n, xfers, errs;
    bit got_done;
    logic [3:0] a, b;
    sum_t obs;
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(6, 20);
      xfers = 0; errs = 0; got_done = 1'b0;
      do_start(8'(n));
      for (int i = 0; i < 200 && !got_done; i++) begin
        a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15));
        obs = ($urandom_range(0, 3) == 0) ? sum_t'($urandom_range(0, 31)) : golden(a, b);
        step($urandom_range(0, 3) != 0, a, b, obs);
        n_cmp++;
        if (s_res_valid !== e_pulse || (e_pulse && s_pass !== e_pass)) begin
          n_fail++;
          $display("FAIL rand verdict @%0d: valid=%b pass=%b required %b/%b", s_cyc, s_res_valid, s_pass, e_pulse, e_pass);
        end
        if (s_xfer) begin
          xfers++;
          if (int'(obs) != int'(a) + int'(b)) errs++;
        end
        got_done = s_done;
      end
      n_cmp++;
      if (!got_done || xfers != n || s_tc !== 8'(n) || s_ec !== 8'(errs)) begin
        n_fail++;
        $display("FAIL rand_run%0d: done=%b xfers=%0d tc=%0d ec=%0d required 1/%0d/%0d/%0d", r, got_done, xfers, s_tc, s_ec, n, n, errs);
      end
    end
  endtask

  task automatic test_saturation;
    int pulses;
    bit bad_pass, got_done;
    pulses = 0; bad_pass = 1'b0; got_done = 1'b0;
    sat_num_tests = 2'd3; sat_start = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    sat_start = 1'b0;
    for (int i = 0; i < 20 && !got_done; i++) begin
      in_valid = (i < 5); num1 = 4'd15; num2 = 4'(i); {cout, out} = 5'd0;
      @(negedge clk);
      if (sat_res_valid) begin
        pulses++;
        if (sat_pass !== 1'b0) bad_pass = 1'b1;
      end
      got_done = sat_done;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (pulses != 3 || bad_pass) begin
      n_fail++;
      $display("FAIL sat_pulses: pulses=%0d any_pass=%b required 3/0", pulses, bad_pass);
    end
    n_cmp++;
    if (!got_done || sat_test_count !== 2'd3 || sat_err_count !== 2'd3) begin
      n_fail++;
      $display("FAIL sat_counts: done=%b tc=%0d ec=%0d required 1/3/3", got_done, sat_test_count, sat_err_count);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_tests = 8'd0; in_valid = 1'b0;
    num1 = 4'd0; num2 = 4'd0; out = 4'd0; cout = 1'b0;
    sat_start = 1'b0; sat_num_tests = 2'd0;
    @(posedge clk); #1;
    test_reset();
    test_rst_midrun();
    test_correct_sums();
    test_error_vector();
    test_back_to_back();
    test_zero_and_ignored_start();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
